// File: rtl/reg_file_mp_pkg.sv
// reg_file_pkg: shared definitions for the multi-port register file.
//   MODE_*  : encodings of the 2-bit read/write conflict mode input
//             (2'b11 is reserved and behaves like MODE_READ_OLD)
//   st_e    : clear-sweep controller state
package reg_file_pkg;

  localparam logic [1:0] MODE_READ_OLD    = 2'b00;
  localparam logic [1:0] MODE_WRITE_FIRST = 2'b01;
  localparam logic [1:0] MODE_WRITE_PRIO  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } st_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: datapath-side bus of the register file.
//   mode      conflict mode (reg_file_pkg::MODE_*)
//   rd_en     per-port read request
//   rd_addr   per-port read address, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   per-port registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_valid  per-port, high the cycle after an accepted read
//   we/wa/wd  write port
//   wr_ready  write back-pressure
//   clr       clear-sweep start pulse
//   busy      clear sweep running
//
// Handshake: a write transfers on a rising edge where we && wr_ready;
// we may be held with wa/wd stable until accepted, and nothing transfers
// while wr_ready is low. Reads have no back-pressure: rd_en sampled at an
// edge produces rd_valid for exactly the following cycle, unless the read
// was blocked (WRITE_PRIO with an accepted write), in which case rd_valid
// stays low and rd_data keeps its previous value.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) ();

  logic [1:0]            mode;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_valid;
  logic                  we;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     wd;
  logic                  wr_ready;
  logic                  clr;
  logic                  busy;

  // master: decode/writeback side driving requests
  modport master (
    output mode, rd_en, rd_addr, we, wa, wd, clr,
    input  rd_data, rd_valid, wr_ready, busy
  );

  // slave: the register file itself
  modport slave (
    input  mode, rd_en, rd_addr, we, wa, wd, clr,
    output rd_data, rd_valid, wr_ready, busy
  );

endinterface

// File: rtl/reg_file_mp_rf_read_port.sv
// rf_read_port: one registered read port of reg_file_mp.
//   CLK, reset    clock, synchronous active-high reset
//   mode_i        conflict mode
//   rd_en_i       read request
//   rd_addr_i     read address
//   mem_data_i    current (pre-write) content of entry rd_addr_i
//   wr_acc_i      a write is being accepted this cycle
//   wa_i, wd_i    address/data of that write
//   clearing_i    clear sweep in progress: accepted reads return 0
//   rd_data_o     registered read data (holds when no read accepted)
//   rd_valid_o    high one cycle after an accepted read
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        mode_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wr_acc_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              clearing_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              accept;
  logic              hit;
  logic              zero_hit;

  always_comb begin
    hit        = wr_acc_i && (wa_i == rd_addr_i);
    zero_hit   = (ZERO_R0 != 0) && (rd_addr_i == '0);
    // WRITE_PRIO: any accepted write stalls every read port for that cycle
    accept     = rd_en_i && !((mode_i == MODE_WRITE_PRIO) && wr_acc_i);
    rd_data_d  = rd_data_q;
    rd_valid_d = accept;
    if (accept) begin
      // the zero-entry mask wins over the bypass
      if (clearing_i || zero_hit) begin
        rd_data_d = '0;
      end else if ((mode_i == MODE_WRITE_FIRST) && hit) begin
        rd_data_d = wd_i;
      end else begin
        rd_data_d = mem_data_i;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with NRD registered read ports,
// one write port, selectable read/write conflict behaviour and a
// DEPTH-cycle clear sweep that back-pressures writes.
//   CLK          clock, all state updates on the rising edge
//   reset        synchronous, active-high; clears every entry
//   bus          reg_file_mp_if slave modport (read/write/clear bus)
//   dbg_state_o  clear-sweep controller state
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic         CLK,
  input  logic         reset,
  reg_file_mp_if.slave bus,
  output st_e          dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  st_e               state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clearing;
  logic              wr_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [DATA_W-1:0] rd_data_w [NRD];
  logic [NRD-1:0]    rd_valid_w;

  // Clear-sweep controller: one entry per cycle, leaves after the last one.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clearing = (state_q == ST_CLEAR);
  assign wr_acc   = bus.we && !clearing;

  // Single storage write port shared by the sweep and normal writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = bus.wa;
    mem_wd = bus.wd;
    if (clearing) begin
      mem_we = 1'b1;
      mem_wa = ptr_q;
      mem_wd = '0;
    end else if (wr_acc && !((ZERO_R0 != 0) && (bus.wa == '0))) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
    ) u_port (
      .CLK       (CLK),
      .reset     (reset),
      .mode_i    (bus.mode),
      .rd_en_i   (bus.rd_en[k]),
      .rd_addr_i (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_data_i(mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]]),
      .wr_acc_i  (wr_acc),
      .wa_i      (bus.wa),
      .wd_i      (bus.wd),
      .clearing_i(clearing),
      .rd_data_o (rd_data_w[k]),
      .rd_valid_o(rd_valid_w[k])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rd_data_w[k];
    end
  end

  assign bus.rd_valid = rd_valid_w;
  assign bus.wr_ready = !clearing;
  assign bus.busy     = clearing;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NRD     = 2;
  localparam int ZERO_R0 = 1;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int EXP_W   = 2 + NRD + NRD*DATA_W;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic reset;
  st_e  dbg_state;

  always #5 CLK = ~CLK;

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

  reg_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_R0(ZERO_R0)
  ) u_dut (
    .CLK        (CLK),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  // Memory is modelled as a plain array. A clear sweep is modelled as
  // "everything reads 0 for DEPTH cycles, writes refused, memory zero".
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_data [NRD];
  logic [NRD-1:0]    m_valid;
  int                m_clr_left;
  logic [EXP_W-1:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic model_step();
    logic              clearing;
    logic              wacc;
    logic [ADDR_W-1:0] a;
    logic [NRD*DATA_W-1:0] d;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int k = 0; k < NRD; k++) m_data[k] = '0;
      m_valid    = '0;
      m_clr_left = 0;
    end else begin
      clearing = (m_clr_left > 0);
      wacc     = bus.we && !clearing;
      for (int k = 0; k < NRD; k++) begin
        a = bus.rd_addr[k*ADDR_W +: ADDR_W];
        m_valid[k] = 1'b0;
        if (bus.rd_en[k] && !(bus.mode == MODE_WRITE_PRIO && wacc)) begin
          m_valid[k] = 1'b1;
          if (clearing || (ZERO_R0 != 0 && a == 0)) m_data[k] = '0;
          else if (bus.mode == MODE_WRITE_FIRST && wacc && bus.wa == a) m_data[k] = bus.wd;
          else m_data[k] = m_mem[a];
        end
      end
      if (wacc && !(ZERO_R0 != 0 && bus.wa == 0)) m_mem[bus.wa] = bus.wd;
      if (clearing) begin
        m_clr_left = m_clr_left - 1;
      end else if (bus.clr) begin
        m_clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
    for (int k = 0; k < NRD; k++) d[k*DATA_W +: DATA_W] = m_data[k];
    exp_q.push_back({m_clr_left > 0, m_clr_left == 0, m_valid, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    model_step();
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    a = {bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_data};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model cycle %0d: got %h expected %h", cyc, a, e);
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.mode    = MODE_READ_OLD;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.we      = 1'b0;
    bus.wa      = '0;
    bus.wd      = '0;
    bus.clr     = 1'b0;
  endtask

  task automatic set_read(input logic [1:0] en, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    bus.rd_en   = en;
    bus.rd_addr = {a1, a0};
  endtask

  task automatic preload();
    set_idle();
    for (int a = 1; a < DEPTH; a++) begin
      bus.we = 1'b1;
      bus.wa = ADDR_W'(a);
      bus.wd = $urandom | 32'h1;
      step();
    end
    set_idle();
  endtask

  task automatic check_all_zero(input string name);
    set_idle();
    for (int i = 0; i < DEPTH/2; i++) begin
      set_read(2'b11, ADDR_W'(2*i), ADDR_W'(2*i+1));
      step();
      chk(name, {30'd0, bus.rd_valid, bus.rd_data}, {30'd0, 2'b11, 64'd0});
    end
    set_idle();
  endtask

  task automatic rand_inputs();
    bus.mode = 2'($urandom_range(0, 3));
    bus.rd_en = 2'($urandom_range(0, 3));
    for (int k = 0; k < NRD; k++)
      bus.rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
    bus.we = ($urandom_range(0, 2) != 0);
    bus.wa = ADDR_W'($urandom_range(0, 7));
    bus.wd = $urandom;
    bus.clr = ($urandom_range(0, 39) == 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]        mode;
    logic [1:0]        en;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] e0;
    logic [DATA_W-1:0] e1;
    logic [1:0]        ev;
  } vec_t;

  vec_t vt [12];

  initial begin
    int busy_cycles;
    int guard;

    vt[0]  = '{2'b00, 2'b11, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b11};
    vt[1]  = '{2'b00, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hAAAA, 32'h0,    32'h0,    2'b00};
    vt[2]  = '{2'b00, 2'b01, 5'd5, 5'd0, 1'b1, 5'd5, 32'h1234, 32'hAAAA, 32'h0,    2'b01};
    vt[3]  = '{2'b00, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,    32'h1234, 32'h1234, 2'b11};
    vt[4]  = '{2'b01, 2'b11, 5'd5, 5'd3, 1'b1, 5'd5, 32'h5678, 32'h5678, 32'h0,    2'b11};
    vt[5]  = '{2'b01, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF, 32'h0,    32'h0,    2'b11};
    vt[6]  = '{2'b01, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    32'h0,    2'b01};
    vt[7]  = '{2'b00, 2'b11, 5'd5, 5'd5, 1'b1, 5'd4, 32'h4444, 32'h5678, 32'h5678, 2'b11};
    vt[8]  = '{2'b10, 2'b11, 5'd4, 5'd9, 1'b1, 5'd9, 32'h9999, 32'h5678, 32'h5678, 2'b00};
    vt[9]  = '{2'b10, 2'b11, 5'd4, 5'd9, 1'b0, 5'd0, 32'h0,    32'h4444, 32'h9999, 2'b11};
    vt[10] = '{2'b11, 2'b01, 5'd9, 5'd0, 1'b1, 5'd9, 32'hAAAA, 32'h9999, 32'h9999, 2'b01};
    vt[11] = '{2'b00, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0,    32'h9999, 32'hAAAA, 2'b10};

    // reset
    set_idle();
    reset = 1'b1;
    step();
    step();
    chk("reset_state", {28'd0, bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_data},
        {28'd0, 1'b0, 1'b1, 2'b00, 64'd0});
    reset = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 12; i++) begin
      bus.mode = vt[i].mode;
      set_read(vt[i].en, vt[i].a0, vt[i].a1);
      bus.we = vt[i].we;
      bus.wa = vt[i].wa;
      bus.wd = vt[i].wd;
      bus.clr = 1'b0;
      step();
      chk($sformatf("vec%0d", i), {30'd0, bus.rd_valid, bus.rd_data},
          {30'd0, vt[i].ev, vt[i].e1, vt[i].e0});
    end
    set_idle();

    // full clear sweep with writes held during it
    preload();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      chk("sweep_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
      bus.we = 1'b1;
      bus.wa = ADDR_W'($urandom_range(1, DEPTH-1));
      bus.wd = $urandom | 32'h1;
      bus.clr = ($urandom_range(0, 1) != 0);
      set_read(2'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 31)), ADDR_W'($urandom_range(0, 31)));
      step();
      if (bus.busy === 1'b1) busy_cycles++;
      guard++;
    end
    set_idle();
    chk("sweep_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
    chk("sweep_done_ready", {62'd0, bus.busy, bus.wr_ready}, {62'd0, 2'b01});
    check_all_zero("sweep_zero");

    // reset in the middle of a sweep
    preload();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.we = 1'b1;
      bus.wa = ADDR_W'($urandom_range(1, DEPTH-1));
      bus.wd = $urandom;
      step();
    end
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midsweep_reset", {28'd0, bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_data},
        {28'd0, 1'b0, 1'b1, 2'b00, 64'd0});
    check_all_zero("midsweep_zero");

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    set_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file; successor to the fixed 32x32 two-read-port register file. Adds generic width, depth and read-port count, a three-way read/write conflict mode, per-port read valids, optional hard-wired zero entry, and a multi-cycle clear sweep with write back-pressure. Sits in the datapath register stage between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 1, when 1 entry 0 always reads 0 and ignores writes
- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- mode  in  2  conflict mode: 00 READ_OLD, 01 WRITE_FIRST, 10 WRITE_PRIO, 11 reserved (behaves as READ_OLD)
- rd_en  in  NRD  per-port read request
- rd_addr  in  NRD*ADDR_W  per-port read address, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  per-port registered read data, same packing
- rd_valid  out  NRD  per-port, high one cycle after an accepted read
- we  in  1  write request
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- wr_ready  out  1  write accepted when we && wr_ready
- clr  in  1  start clear sweep (pulse)
- busy  out  1  high while clear sweep runs

## Operation
- Reset: all entries 0, rd_data 0, rd_valid 0, FSM to IDLE, busy 0, wr_ready 1. Reset overrides clr, we, rd_en.
- FSM: IDLE -> CLEAR on clr (in IDLE); CLEAR writes 0 to entry ptr, ptr += 1 per cycle; CLEAR -> IDLE after entry DEPTH-1 written. clr during CLEAR ignored. Sweep = DEPTH cycles, busy high exactly those cycles.
- In CLEAR: wr_ready 0 (writes not accepted); reads accepted, rd_data 0, rd_valid 1 for enabled ports.
- In IDLE, write accepted whenever we; mem[wa] <= wd at edge (not if ZERO_R0 && wa==0).
- Read accepted on port k when rd_en[k] and not blocked; rd_data_k registered at edge, rd_valid[k] 1 next cycle; not accepted -> rd_data_k holds, rd_valid[k] 0.
- Conflict (accepted write with wa == rd_addr_k):
  - READ_OLD: rd_data_k = pre-write content.
  - WRITE_FIRST: rd_data_k = wd (bypass).
  - WRITE_PRIO: any accepted write blocks all reads that cycle (any address); rd_valid 0, rd_data holds.
- Non-conflicting reads return current content in all modes except WRITE_PRIO blocking.
- ZERO_R0: read of address 0 returns 0 regardless of mode/bypass.
- Multiple ports reading the same address all receive identical data.

## Timing
- Read latency 1 cycle: address/rd_en at edge N -> rd_data/rd_valid valid after edge N, until edge N+1.
- Write visible to non-bypassed reads issued from the cycle after acceptance.
- clr at edge N -> busy 1 after N through edge N+DEPTH; wr_ready 1 again after edge N+DEPTH.
- reset asserted mid-sweep: busy 0 and all entries 0 after that edge; sweep abandoned.
- mode sampled each cycle, changes take effect immediately, no pipeline state.

## Structure
- Package reg_file_pkg: mode constants (MODE_READ_OLD, MODE_WRITE_FIRST, MODE_WRITE_PRIO), FSM state type (ST_IDLE, ST_CLEAR).
- One sub-module rf_read_port (instantiated NRD times via generate): address compare, bypass mux, zero-entry mask, output register and valid. Storage array, write logic and clear FSM in top.

## Test plan
- reset, then read ports 0/1 at addresses 3/7 -> rd_data 0, rd_valid 11 one cycle later.
- READ_OLD: mem[5]=0xAAAA; same cycle write 0x1234 to 5 and read 5 -> rd_data 0xAAAA; next read -> 0x1234.
- WRITE_FIRST: same stimulus -> rd_data 0x1234 same-cycle; ZERO_R0 write 0xFFFF to 0 then read 0 -> 0.
- WRITE_PRIO: write to 9 while reading 4 and 9 -> rd_valid 00, rd_data unchanged; next cycle reads valid with 0x...new.
- clr with DEPTH=32, entries preloaded -> busy 32 cycles, wr_ready 0, we ignored (mem unchanged after), all entries read 0 afterwards.
- reset asserted at cycle 10 of sweep -> busy 0 next cycle, wr_ready 1, all entries 0.
